// File: rtl/mem_access.sv
// mem_access: EX/MEM-stage data-memory access unit with an IDLE/WAIT/DONE bus handshake FSM.
// Defining MEM_ACCESS_TIMEOUT_EN builds a 255-cycle WAIT timeout that reports busError.
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_writebackEnable,
  input  logic [4:0]  EX_writebackAddress,
  input  logic [31:0] EX_writebackData,
  input  logic [3:0]  EX_memOp,
  input  logic [31:0] EX_storeData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_writebackEnable,
  output logic [4:0]  MEM_writebackAddress,
  output logic [31:0] MEM_writebackData,
  output logic        stallRequest,
  output logic        misaligned,
  output logic        busError
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  ofs;
  logic        is_load, is_store, is_misaligned;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic        req, timeout;

  assign ofs       = EX_writebackData[1:0];
  assign dmem_addr = {EX_writebackData[31:2], 2'b00};

  // Operation decode, byte enables and lane-replicated store data.
  always_comb begin
    is_load       = 1'b0;
    is_store      = 1'b0;
    is_misaligned = 1'b0;
    dmem_be       = 4'b1111;
    dmem_wdata    = EX_storeData;
    case (EX_memOp)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load       = 1'b1;
        is_misaligned = ofs[0];
      end
      OP_LW: begin
        is_load       = 1'b1;
        is_misaligned = |ofs;
      end
      OP_SB: begin
        is_store   = 1'b1;
        dmem_be    = 4'b0001 << ofs;
        dmem_wdata = {4{EX_storeData[7:0]}};
      end
      OP_SH: begin
        is_store      = 1'b1;
        is_misaligned = ofs[0];
        dmem_be       = ofs[1] ? 4'b1100 : 4'b0011;
        dmem_wdata    = {2{EX_storeData[15:0]}};
      end
      OP_SW: begin
        is_store      = 1'b1;
        is_misaligned = |ofs;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ofs)
      2'd0:    lane_b = rdata_q[7:0];
      2'd1:    lane_b = rdata_q[15:8];
      2'd2:    lane_b = rdata_q[23:16];
      default: lane_b = rdata_q[31:24];
    endcase
    lane_h = ofs[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (EX_memOp)
      OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_val = {24'd0, lane_b};
      OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_val = {16'd0, lane_h};
      default: load_val = rdata_q;
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       bus_err_q, bus_err_d;

  // cnt_q == 254 marks the 255th consecutive WAIT cycle.
  assign timeout  = (cnt_q == 8'd254);
  assign busError = bus_err_q;

  always_comb begin
    cnt_d     = (state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
    bus_err_d = (state_q == WAIT) && timeout && !dmem_ack;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
`else
  assign timeout  = 1'b0;
  assign busError = 1'b0;
`endif

  always_comb begin
    state_d              = state_q;
    rdata_d              = rdata_q;
    req                  = 1'b0;
    stallRequest         = 1'b0;
    misaligned           = 1'b0;
    MEM_writebackEnable  = 1'b0;
    MEM_writebackAddress = EX_writebackAddress;
    MEM_writebackData    = EX_writebackData;
    case (state_q)
      IDLE: begin
        if (is_misaligned) begin
          misaligned = 1'b1;
        end else if (is_load || is_store) begin
          req          = 1'b1;
          stallRequest = 1'b1;
          if (dmem_ack) begin
            rdata_d = dmem_rdata;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          MEM_writebackEnable = EX_writebackEnable;
        end
      end
      WAIT: begin
        req          = 1'b1;
        stallRequest = 1'b1;
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          state_d = DONE;
        end else if (timeout) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d             = IDLE;
        MEM_writebackEnable = is_load & EX_writebackEnable & ~busError;
        if (is_load) MEM_writebackData = load_val;
      end
      default: state_d = IDLE;
    endcase
    // Reset must silence the bus and pipeline controls within the same cycle.
    if (reset) begin
      req                 = 1'b0;
      stallRequest        = 1'b0;
      misaligned          = 1'b0;
      MEM_writebackEnable = 1'b0;
    end
  end

  assign dmem_req = req;
  assign dmem_we  = req & is_store;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access: a transaction-level model predicts every
// output cycle by cycle, plus directed literal cases for the headline scenarios.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset;
  logic        EX_writebackEnable;
  logic [4:0]  EX_writebackAddress;
  logic [31:0] EX_writebackData;
  logic [3:0]  EX_memOp;
  logic [31:0] EX_storeData;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        MEM_writebackEnable;
  logic [4:0]  MEM_writebackAddress;
  logic [31:0] MEM_writebackData;
  logic        stallRequest, misaligned, busError;

  mem_access dut (
    .clk(clk), .reset(reset),
    .EX_writebackEnable(EX_writebackEnable), .EX_writebackAddress(EX_writebackAddress),
    .EX_writebackData(EX_writebackData), .EX_memOp(EX_memOp), .EX_storeData(EX_storeData),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .MEM_writebackEnable(MEM_writebackEnable), .MEM_writebackAddress(MEM_writebackAddress),
    .MEM_writebackData(MEM_writebackData), .stallRequest(stallRequest),
    .misaligned(misaligned), .busError(busError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        req0, we0, stall0, mis0, wbe0;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0, wbd0;
    logic [15:0] stall_cycles;
    logic [31:0] done_wbd;
    logic        done_wbe, done_berr, done_stall, done_req;
  } obs_t;

  // Model expectations for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_req, exp_stall, exp_mis, exp_wbe, exp_berr, exp_we;
  logic [4:0]  exp_wba;
  logic [31:0] exp_wbd, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        exp_chk_wbd, exp_chk_wba, exp_chk_bus, exp_chk_wdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic bit model_mis(input logic [3:0] op, input logic [31:0] a);
    int low = int'(a % 4);
    if (op == 4'd3 || op == 4'd4 || op == 4'd7) return (low % 2) != 0;
    if (op == 4'd5 || op == 4'd8) return low != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] a);
    int low = int'(a % 4);
    if (op == 4'd6) return 4'(1 << low);
    if (op == 4'd7) return 4'(3 << (low / 2 * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] sd);
    if (op == 4'd6) return (sd % 256) * 32'h0101_0101;
    if (op == 4'd7) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    int low = int'(a % 4);
    longint v;
    case (op)
      4'd1, 4'd2: begin
        v = longint'((rd >> (8 * low)) % 256);
        if (op == 4'd1 && v >= 128) v = v - 256;
      end
      4'd3, 4'd4: begin
        v = longint'((rd >> (16 * (low / 2))) % 65536);
        if (op == 4'd3 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rd);
    endcase
    return 32'(v);
  endfunction

  // Single compare process: every cycle while the model is active
  always @(negedge clk) begin
    if (chk_en) begin
      check("dmem_req", dmem_req, exp_req);
      check("stallRequest", stallRequest, exp_stall);
      check("misaligned", misaligned, exp_mis);
      check("MEM_wbe", MEM_writebackEnable, exp_wbe);
      check("busError", busError, exp_berr);
      if (exp_chk_wba) check("MEM_wba", MEM_writebackAddress, exp_wba);
      if (exp_chk_wbd) check("MEM_wbd", MEM_writebackData, exp_wbd);
      if (exp_chk_bus) begin
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_we", dmem_we, exp_we);
        check("dmem_be", dmem_be, exp_be);
      end
      if (exp_chk_wdata) check("dmem_wdata", dmem_wdata, exp_wdata);
    end
  end

  // lat = cycle index (0 = issue cycle) in which ack arrives
  task automatic do_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic en, input logic [4:0] wa, input int lat,
                        input logic [31:0] rd, output obs_t o);
    bit ld, st, mis, tout;
    int ncyc;
    ld   = (op >= 4'd1 && op <= 4'd5);
    st   = (op >= 4'd6 && op <= 4'd8);
    mis  = model_mis(op, a);
    tout = 1'b0;
    o    = '0;
    EX_memOp = op; EX_writebackData = a; EX_storeData = sd;
    EX_writebackEnable = en; EX_writebackAddress = wa;
    exp_wba = wa; exp_berr = 1'b0; exp_we = st;
    exp_addr = a & 32'hFFFF_FFFC; exp_be = model_be(op, a); exp_wdata = model_wdata(op, sd);
    if (!(ld || st) || mis) begin
      exp_req = 1'b0; exp_stall = 1'b0; exp_mis = mis; exp_wbe = mis ? 1'b0 : en;
      exp_wbd = a; exp_chk_wbd = !mis; exp_chk_wba = 1'b1;
      exp_chk_bus = 1'b0; exp_chk_wdata = 1'b0;
      dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      @(negedge clk);
      o.req0 = dmem_req; o.stall0 = stallRequest; o.mis0 = misaligned;
      o.wbe0 = MEM_writebackEnable; o.wbd0 = MEM_writebackData;
      @(posedge clk); #1;
    end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
      if (lat > 255) tout = 1'b1;
`endif
      ncyc = tout ? 256 : lat + 1;
      for (int c = 0; c < ncyc; c++) begin
        exp_req = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0; exp_wbe = 1'b0;
        exp_chk_wbd = 1'b0; exp_chk_wba = 1'b0; exp_chk_bus = 1'b1; exp_chk_wdata = st;
        dmem_ack = (!tout && c == lat);
        dmem_rdata = dmem_ack ? rd : $urandom;
        @(negedge clk);
        if (c == 0) begin
          o.req0 = dmem_req; o.we0 = dmem_we; o.stall0 = stallRequest; o.mis0 = misaligned;
          o.wbe0 = MEM_writebackEnable; o.be0 = dmem_be; o.addr0 = dmem_addr;
          o.wdata0 = dmem_wdata;
        end
        if (stallRequest) o.stall_cycles = o.stall_cycles + 16'd1;
        @(posedge clk); #1;
      end
      exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_berr = tout;
      exp_wbe = ld && en && !tout; exp_wbd = model_load(op, a, rd);
      exp_chk_wbd = ld && !tout; exp_chk_wba = 1'b1; exp_chk_bus = 1'b0; exp_chk_wdata = 1'b0;
      dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      @(negedge clk);
      o.done_wbd = MEM_writebackData; o.done_wbe = MEM_writebackEnable;
      o.done_berr = busError; o.done_stall = stallRequest; o.done_req = dmem_req;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    logic [3:0]  op;
    logic [31:0] a;
    // Reset with a misaligned LW presented: everything must stay quiet
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    EX_memOp = 4'd5; EX_writebackData = 32'h101; EX_storeData = 32'd0;
    EX_writebackEnable = 1'b1; EX_writebackAddress = 5'd1;
    @(negedge clk);
    check("rst_mis", misaligned, 1'b0);
    check("rst_req", dmem_req, 1'b0);
    check("rst_stall", stallRequest, 1'b0);
    check("rst_wbe", MEM_writebackEnable, 1'b0);
    check("rst_berr", busError, 1'b0);
    EX_writebackData = 32'h100; #1;
    check("rst_req_aligned", dmem_req, 1'b0);
    check("rst_stall_aligned", stallRequest, 1'b0);
    @(posedge clk); #1;
    EX_memOp = 4'd0;
    reset = 1'b0;
    chk_en = 1'b1;

    // Headline scenarios with hand-computed values
    do_txn(4'd0, 32'h1234_5678, 32'd0, 1'b1, 5'd9, 0, 32'd0, o);
    check("pass_wbd", o.wbd0, 32'h1234_5678);
    check("pass_wbe", o.wbe0, 1'b1);
    check("pass_req", o.req0, 1'b0);
    do_txn(4'd1, 32'h103, 32'd0, 1'b1, 5'd4, 3, 32'h80FF_FFFF, o);
    check("lb_stall_cycles", o.stall_cycles, 16'd4);
    check("lb_data", o.done_wbd, 32'hFFFF_FF80);
    check("lb_done_stall", o.done_stall, 1'b0);
    do_txn(4'd7, 32'h202, 32'h0000_ABCD, 1'b1, 5'd5, 1, 32'd0, o);
    check("sh_be", o.be0, 4'b1100);
    check("sh_wdata", o.wdata0, 32'hABCD_ABCD);
    check("sh_addr", o.addr0, 32'h200);
    check("sh_we", o.we0, 1'b1);
    check("sh_done_wbe", o.done_wbe, 1'b0);
    do_txn(4'd5, 32'h101, 32'd0, 1'b1, 5'd6, 0, 32'd0, o);
    check("lw_mis", o.mis0, 1'b1);
    check("lw_mis_req", o.req0, 1'b0);
    check("lw_mis_stall", o.stall0, 1'b0);
    check("lw_mis_wbe", o.wbe0, 1'b0);
    do_txn(4'd3, 32'h102, 32'd0, 1'b1, 5'd7, 0, 32'h8001_0000, o);
    check("lh_data", o.done_wbd, 32'hFFFF_8001);
    do_txn(4'd4, 32'h102, 32'd0, 1'b1, 5'd0, 2, 32'h8001_0000, o);
    check("lhu_data_r0", o.done_wbd, 32'h0000_8001);
    check("lhu_wbe_r0", o.done_wbe, 1'b1);
    do_txn(4'd6, 32'h001, 32'h0000_0012, 1'b1, 5'd8, 0, 32'd0, o);
    check("sb_be", o.be0, 4'b0010);
    check("sb_wdata", o.wdata0, 32'h1212_1212);
`ifdef MEM_ACCESS_TIMEOUT_EN
    do_txn(4'd5, 32'h300, 32'd0, 1'b1, 5'd3, 1000, 32'd0, o);
    check("to_stall_cycles", o.stall_cycles, 16'd256);
    check("to_berr", o.done_berr, 1'b1);
    check("to_done_stall", o.done_stall, 1'b0);
    check("to_done_req", o.done_req, 1'b0);
`endif

    // Randomized transactions against the model
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      do_txn(op, a, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom_range(0, 4), $urandom, o);
    end

    // Reset during WAIT, then a stale ack must be ignored
    chk_en = 1'b0;
    EX_memOp = 4'd5; EX_writebackData = 32'h100; EX_writebackEnable = 1'b1;
    EX_writebackAddress = 5'd3; dmem_ack = 1'b0;
    @(posedge clk); #2;
    check("wait_req_before_rst", dmem_req, 1'b1);
    reset = 1'b1; #1;
    check("midrst_req", dmem_req, 1'b0);
    check("midrst_stall", stallRequest, 1'b0);
    check("midrst_wbe", MEM_writebackEnable, 1'b0);
    @(posedge clk); #1;
    EX_memOp = 4'd0; EX_writebackData = 32'h55; EX_writebackAddress = 5'd7;
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stale_ack_req", dmem_req, 1'b0);
    check("stale_ack_wbd", MEM_writebackData, 32'h55);
    check("stale_ack_wbe", MEM_writebackEnable, 1'b1);
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_txn(4'd5, 32'h104, 32'd0, 1'b1, 5'd2, 1, 32'h0BAD_F00D, o);
    check("post_rst_idle_req", o.req0, 1'b1);
    check("post_rst_lw", o.done_wbd, 32'h0BAD_F00D);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
